// File: rtl/fetch_buffer.sv
// fetch_buffer: one-at-a-time instruction fetch feeding a DEPTH-entry {pc, inst} FIFO, with flush/kill.
// Optional FETCH_ALIGN_CHECK_EN: misaligned PCs skip memory and enqueue a faulting NOP.
module fetch_buffer #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PC_WIDTH-1:0]         pc_i,
    input  logic                        pc_valid_i,
    output logic                        pc_ready_o,
    input  logic                        flush_i,
    output logic                        imem_req_o,
    output logic [PC_WIDTH-1:0]         imem_addr_o,
    input  logic                        imem_gnt_i,
    input  logic                        imem_rvalid_i,
    input  logic [INST_WIDTH-1:0]       imem_rdata_i,
    output logic                        inst_valid_o,
    input  logic                        inst_ready_i,
    output logic [INST_WIDTH-1:0]       inst_o,
    output logic [PC_WIDTH-1:0]         inst_pc_o,
    output logic                        inst_fault_o,
    output logic [$clog2(DEPTH):0]      count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, FAULT} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA} state_t;
`endif

    state_t                  state;
    logic [PC_WIDTH-1:0]     cap_pc;
    logic                    kill;
    logic [AW-1:0]           wptr, rptr;
    logic [PC_WIDTH-1:0]     mem_pc   [DEPTH];
    logic [INST_WIDTH-1:0]   mem_inst [DEPTH];
    logic                    accept, push, pop;
    logic [INST_WIDTH-1:0]   push_inst;

    assign pc_ready_o   = (state == IDLE) && (count_o < CW'(DEPTH)) && !flush_i;
    assign accept       = pc_ready_o && pc_valid_i;
    assign inst_valid_o = (count_o != '0) && !flush_i;
    assign pop          = inst_valid_o && inst_ready_i;
    assign inst_o       = mem_inst[rptr];
    assign inst_pc_o    = mem_pc[rptr];

`ifdef FETCH_ALIGN_CHECK_EN
    logic                    misaligned;
    logic                    mem_fault [DEPTH];
    assign misaligned   = pc_i[1:0] != 2'b00;
    assign push         = (state == WAIT_DATA && imem_rvalid_i && !kill) || state == FAULT;
    assign push_inst    = state == FAULT ? INST_WIDTH'(32'h00000013) : imem_rdata_i;
    assign inst_fault_o = mem_fault[rptr] && count_o != '0;
    always_ff @(posedge clk)
        if (push) mem_fault[wptr] <= state == FAULT;
`else
    assign push         = state == WAIT_DATA && imem_rvalid_i && !kill;
    assign push_inst    = imem_rdata_i;
    assign inst_fault_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            imem_req_o  <= 1'b0;
            imem_addr_o <= '0;
            cap_pc      <= '0;
            kill        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    imem_addr_o <= pc_i;
                    cap_pc      <= pc_i;
`ifdef FETCH_ALIGN_CHECK_EN
                    state       <= misaligned ? FAULT : REQ;
                    imem_req_o  <= !misaligned;
`else
                    state       <= REQ;
                    imem_req_o  <= 1'b1;
`endif
                end
                REQ: begin
                    if (imem_gnt_i) begin
                        state      <= WAIT_DATA;
                        imem_req_o <= 1'b0;
                    end
                    if (flush_i) kill <= 1'b1;
                end
                WAIT_DATA: begin
                    if (imem_rvalid_i) begin
                        state <= IDLE;
                        kill  <= 1'b0;
                    end else if (flush_i) begin
                        kill  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // flush wins over any same-cycle push, so the reset branch also discards it
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr    <= '0;
            rptr    <= '0;
            count_o <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count_o <= count_o + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wptr]   <= cap_pc;
            mem_inst[wptr] <= push_inst;
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: table-driven cycle vectors plus hand-written slow-memory and alignment sequences.
module tb_fetch_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_fault_o;
    logic [1:0]  count_o;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fetch_buffer #(.PC_WIDTH(32), .INST_WIDTH(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
        .flush_i(flush_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
        .inst_pc_o(inst_pc_o), .inst_fault_o(inst_fault_o), .count_o(count_o)
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        pv, fl, gnt, rv;
        logic [31:0] rd;
        logic        rdy;
        logic        e_prdy, e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst, e_ipc;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic r, input logic [31:0] pc, input logic pv, fl, gnt, rv,
                       input logic [31:0] rd, input logic rdy, input logic e_prdy, e_req,
                       input logic [31:0] e_addr, input logic e_iv,
                       input logic [31:0] e_inst, e_ipc, input logic [1:0] e_cnt);
        tbl.push_back('{r, pc, pv, fl, gnt, rv, rd, rdy, e_prdy, e_req, e_addr, e_iv, e_inst, e_ipc, e_cnt});
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; pc_i = v.pc; pc_valid_i = v.pv; flush_i = v.fl;
        imem_gnt_i = v.gnt; imem_rvalid_i = v.rv; imem_rdata_i = v.rd; inst_ready_i = v.rdy;
    endtask

    task automatic idle_inputs();
        rst = 0; pc_valid_i = 0; flush_i = 0; imem_gnt_i = 0;
        imem_rvalid_i = 0; imem_rdata_i = 0; inst_ready_i = 0;
    endtask

    // slow memory: gnt after two held cycles, rvalid two cycles after gnt
    task automatic slow_fetch(input logic [31:0] pc, input logic [31:0] data);
        int n;
        @(negedge clk); idle_inputs(); pc_i = pc; pc_valid_i = 1;
        #1 chk("slow_pc_ready", pc_ready_o, 1);
        @(negedge clk); pc_valid_i = 0;
        n = 0;
        while (!imem_req_o && n < 10) begin @(negedge clk); n++; end
        chk("slow_req", imem_req_o, 1);
        chk("slow_addr", imem_addr_o, pc);
        repeat (2) @(negedge clk);
        chk("slow_req_held", imem_req_o, 1);
        chk("slow_addr_held", imem_addr_o, pc);
        imem_gnt_i = 1;
        @(negedge clk); imem_gnt_i = 0;
        chk("slow_req_drop", imem_req_o, 0);
        @(negedge clk); imem_rvalid_i = 1; imem_rdata_i = data;
        @(negedge clk); imem_rvalid_i = 0;
        n = 0;
        while (!inst_valid_o && n < 10) begin @(negedge clk); n++; end
        chk("slow_valid", inst_valid_o, 1);
        chk("slow_inst", inst_o, data);
        chk("slow_pc", inst_pc_o, pc);
        chk("slow_fault", inst_fault_o, 0);
        inst_ready_i = 1;
        @(negedge clk); inst_ready_i = 0;
        chk("slow_popped", count_o, 0);
    endtask

    initial begin
        // r  pc  pv fl gnt rv rd  rdy | prdy req addr iv inst  ipc  cnt
        add(0, 32'h100, 1,0,0,0, 0, 0,  1,0, 0,     0, 0, 0, 0);
        add(0, 0,       0,0,1,0, 0, 0,  0,1, 32'h100, 0, 0, 0, 0);
        add(0, 0,       0,0,0,1, 32'h00500093, 0, 0,0, 0, 0, 0, 0, 0);
        add(0, 0,       0,0,0,0, 0, 1,  1,0, 0, 1, 32'h00500093, 32'h100, 1);
        add(0, 32'h0,   1,0,0,0, 0, 0,  1,0, 0, 0, 0, 0, 0);
        add(0, 0,       0,0,0,0, 0, 0,  0,1, 32'h0, 0, 0, 0, 0);
        add(0, 0,       0,0,1,0, 0, 0,  0,1, 32'h0, 0, 0, 0, 0);
        add(0, 0,       0,0,0,0, 0, 0,  0,0, 0, 0, 0, 0, 0);
        add(0, 0,       0,0,0,1, 32'hAAAA0001, 0, 0,0, 0, 0, 0, 0, 0);
        add(0, 32'h4,   1,0,0,0, 0, 0,  1,0, 0, 1, 32'hAAAA0001, 32'h0, 1);
        add(0, 0,       0,0,1,0, 0, 0,  0,1, 32'h4, 1, 32'hAAAA0001, 32'h0, 1);
        add(0, 0,       0,0,0,1, 32'hBBBB0002, 0, 0,0, 0, 1, 32'hAAAA0001, 32'h0, 1);
        add(0, 32'h8,   1,0,0,0, 0, 0,  0,0, 0, 1, 32'hAAAA0001, 32'h0, 2);
        add(0, 32'h8,   1,0,0,0, 0, 1,  0,0, 0, 1, 32'hAAAA0001, 32'h0, 2);
        add(0, 0,       0,0,0,0, 0, 0,  1,0, 0, 1, 32'hBBBB0002, 32'h4, 1);
        add(0, 32'hC,   1,0,0,0, 0, 0,  1,0, 0, 1, 32'hBBBB0002, 32'h4, 1);
        add(0, 0,       0,0,1,0, 0, 0,  0,1, 32'hC, 1, 32'hBBBB0002, 32'h4, 1);
        add(0, 0,       0,0,0,1, 32'hCCCC0003, 1, 0,0, 0, 1, 32'hBBBB0002, 32'h4, 1);
        add(0, 0,       0,0,0,0, 0, 1,  1,0, 0, 1, 32'hCCCC0003, 32'hC, 1);
        add(0, 0,       0,0,0,0, 0, 0,  1,0, 0, 0, 0, 0, 0);
        add(0, 32'h20,  1,0,0,0, 0, 0,  1,0, 0, 0, 0, 0, 0);
        add(0, 0,       0,0,1,0, 0, 0,  0,1, 32'h20, 0, 0, 0, 0);
        add(0, 0,       0,1,0,0, 0, 0,  0,0, 0, 0, 0, 0, 0);
        add(0, 0,       0,0,0,1, 32'hDEAD0000, 0, 0,0, 0, 0, 0, 0, 0);
        add(0, 32'h24,  1,0,0,0, 0, 0,  1,0, 0, 0, 0, 0, 0);
        add(0, 0,       0,0,1,0, 0, 0,  0,1, 32'h24, 0, 0, 0, 0);
        add(0, 0,       0,0,0,1, 32'h11110024, 0, 0,0, 0, 0, 0, 0, 0);
        add(0, 0,       0,1,0,0, 0, 1,  0,0, 0, 0, 0, 0, 1);
        add(0, 0,       0,0,0,0, 0, 0,  1,0, 0, 0, 0, 0, 0);
        add(0, 32'h30,  1,0,0,0, 0, 0,  1,0, 0, 0, 0, 0, 0);
        add(0, 0,       0,1,0,0, 0, 0,  0,1, 32'h30, 0, 0, 0, 0);
        add(0, 0,       0,0,1,0, 0, 0,  0,1, 32'h30, 0, 0, 0, 0);
        add(0, 0,       0,0,0,1, 32'h00000099, 0, 0,0, 0, 0, 0, 0, 0);
        add(0, 0,       0,0,0,0, 0, 0,  1,0, 0, 0, 0, 0, 0);
        add(0, 32'h40,  1,0,0,0, 0, 0,  1,0, 0, 0, 0, 0, 0);
        add(1, 0,       0,0,0,0, 0, 0,  0,1, 32'h40, 0, 0, 0, 0);
        add(1, 0,       0,0,0,0, 0, 0,  1,0, 0, 0, 0, 0, 0);
        add(0, 0,       0,0,0,0, 0, 0,  1,0, 0, 0, 0, 0, 0);

        idle_inputs(); pc_i = 0; rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0;
        #1 chk("reset_count", count_o, 0);
        chk("reset_req", imem_req_o, 0);
        chk("reset_valid", inst_valid_o, 0);
        chk("reset_fault", inst_fault_o, 0);
        chk("reset_pc_ready", pc_ready_o, 1);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d_pc_ready", i), pc_ready_o, tbl[i].e_prdy);
            chk($sformatf("v%0d_req", i), imem_req_o, tbl[i].e_req);
            if (tbl[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr_o, tbl[i].e_addr);
            chk($sformatf("v%0d_valid", i), inst_valid_o, tbl[i].e_iv);
            if (tbl[i].e_iv) begin
                chk($sformatf("v%0d_inst", i), inst_o, tbl[i].e_inst);
                chk($sformatf("v%0d_inst_pc", i), inst_pc_o, tbl[i].e_ipc);
                chk($sformatf("v%0d_fault", i), inst_fault_o, 0);
            end
            chk($sformatf("v%0d_count", i), count_o, tbl[i].e_cnt);
        end

        slow_fetch(32'h200, 32'h12345678);
`ifdef FETCH_ALIGN_CHECK_EN
        @(negedge clk); idle_inputs(); pc_i = 32'h102; pc_valid_i = 1;
        #1 chk("align_pc_ready", pc_ready_o, 1);
        @(negedge clk); pc_valid_i = 0;
        chk("align_no_req", imem_req_o, 0);
        @(negedge clk);
        chk("align_no_req2", imem_req_o, 0);
        chk("align_valid", inst_valid_o, 1);
        chk("align_inst", inst_o, 32'h00000013);
        chk("align_fault", inst_fault_o, 1);
        chk("align_pc", inst_pc_o, 32'h102);
        inst_ready_i = 1;
        @(negedge clk); inst_ready_i = 0;
        chk("align_popped", count_o, 0);
`else
        slow_fetch(32'h102, 32'hCAFE0102);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction-fetch stage directly downstream of the PC counter unit.
- Accepts a PC, issues one request at a time to instruction memory, and captures the returned word.
- Queues {PC, instruction} pairs in a DEPTH-entry FIFO for the decode stage.
- Supports flush on branch/jump redirect; backpressures the PC source while the FIFO is full or a request is in flight.

Parameters:
PC_WIDTH, 32, PC / address width
INST_WIDTH, 32, instruction word width
DEPTH, 2, FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
pc_i  in  PC_WIDTH  fetch address from PC counter
pc_valid_i  in  1  pc_i valid
pc_ready_o  out  1  buffer accepts pc_i this cycle
flush_i  in  1  redirect: discard all queued and in-flight fetches
imem_req_o  out  1  memory request
imem_addr_o  out  PC_WIDTH  request address
imem_gnt_i  in  1  request accepted by memory
imem_rvalid_i  in  1  read data valid (exactly one per granted request, >=1 cycle after gnt)
imem_rdata_i  in  INST_WIDTH  read data
inst_valid_o  out  1  FIFO head valid
inst_ready_i  in  1  decode consumes head
inst_o  out  INST_WIDTH  head instruction
inst_pc_o  out  PC_WIDTH  head PC
inst_fault_o  out  1  head is misaligned-fetch fault
count_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset is synchronous, active-high, on clk; it is decided and not configurable.
- Reset values:
  - state=IDLE, count_o=0, imem_req_o=0, imem_addr_o=0, kill=0.
  - inst_valid_o=0, inst_fault_o=0.
  - FIFO pointers=0; data contents don't-care.
- FSM states: IDLE, REQ, WAIT_DATA.
- IDLE:
  - pc_ready_o = (count_o < DEPTH) && !flush_i. pc_ready_o is 0 in all other states.
  - Handshake on pc_valid_i && pc_ready_o: latch pc_i into imem_addr_o and the capture-PC register; next state REQ.
- REQ:
  - imem_req_o=1 and imem_addr_o is held stable until imem_gnt_i.
  - On imem_gnt_i -> WAIT_DATA.
  - The request is never withdrawn, even on flush.
- WAIT_DATA:
  - imem_req_o=0.
  - On imem_rvalid_i: if kill=0 and flush_i=0, push {capture-PC, imem_rdata_i, fault=0}.
  - Always -> IDLE and clear kill.
- kill: set when flush_i=1 while state is REQ or WAIT_DATA. Returned data for a killed request is dropped.
- Flush:
  - count_o, read and write pointers -> 0 next cycle.
  - A push in the same cycle is discarded.
  - inst_valid_o is forced 0 combinationally while flush_i=1, so no pop occurs.
- FIFO:
  - inst_valid_o = (count_o!=0) && !flush_i.
  - Pop on inst_valid_o && inst_ready_i.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Push space is guaranteed, because a PC is only accepted when count_o<DEPTH and count cannot increase while a request is outstanding.
- Latency and throughput:
  - PC accepted at cycle t -> imem_req_o at t+1.
  - With gnt at t+1 and rvalid at t+2, the entry is written at the end of t+2 and inst_valid_o=1 at t+3.
  - The next PC can be accepted at t+3, giving a peak throughput of one fetch per 3 cycles.
- Outputs inst_o, inst_pc_o and inst_fault_o are driven from the registered FIFO head (no combinational path from imem_rdata_i).
- No address arithmetic is performed; imem_addr_o is pc_i unmodified.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - An accepted PC with pc_i[1:0]!=0 issues no memory request.
  - Next cycle it pushes {pc, 32'h00000013, fault=1} directly, then returns to IDLE.
  - If flush_i is asserted in that push cycle, the push is discarded.
- Undefined:
  - All PCs are fetched normally; inst_fault_o is tied 0 and the fault FIFO bit is omitted.

Test Plan:
- Reset: hold rst 2 cycles mid-fetch -> count_o=0, imem_req_o=0, inst_valid_o=0, pc_ready_o=1 the cycle after release.
- Single fetch, pc_i=0x100, gnt same cycle as req, rvalid 1 cycle later with 0x00500093 -> inst_valid_o=1 at t+3, inst_pc_o=0x100, inst_o=0x00500093, count_o=1.
- Backpressure with DEPTH=2, inst_ready_i=0:
  - Fetch 0x0 and 0x4 -> count_o=2, pc_ready_o=0.
  - Raise inst_ready_i for one cycle -> head 0x0 pops; pc_ready_o=1 next cycle; 0x4 becomes head.
- Flush in WAIT_DATA: fetch 0x20, assert flush_i 1 cycle before rvalid -> data dropped, count_o=0, inst_valid_o=0, next PC accepted in IDLE.
- Simultaneous push/pop, count_o=1: rvalid and inst_ready_i in the same cycle -> count_o stays 1, new entry at head next cycle.
- FETCH_ALIGN_CHECK_EN, pc_i=0x102 -> imem_req_o never asserted; entry inst_o=0x00000013, inst_fault_o=1, inst_pc_o=0x102.
